// File: rtl/updown_pkg.sv
// Shared types and constants for the triangle sweep controller and its counter.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned SW_W_DEF  = 4;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Host-side control/status bundle of the sweep controller.
interface updown_sweep_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW_W  = 4
);
  logic             start;
  logic             abort;
  logic             hold;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [SW_W-1:0]  n_sweeps;
  logic [WIDTH-1:0] count;
  logic             mode;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, hold, lo, hi, n_sweeps,
    input  count, mode, busy, done, err
  );

  modport slave (
    input  start, abort, hold, lo, hi, n_sweeps,
    output count, mode, busy, done, err
  );
endinterface

// File: rtl/updown_core.sv
// Up/down counter datapath: load has priority over a count step.
module updown_core
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (mode == MODE_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer: drives updown_core between latched limits for n sweeps
// and reports busy/done/err to the host.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  updown_sweep_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_UP   = UP;
  localparam logic [1:0] ST_DOWN = DOWN;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [SW_W-1:0]  n_q, sweep_q, sweep_nxt;
  logic             busy_q, done_q, err_q;
  logic [WIDTH-1:0] count_w;

  logic load, en, dir;
  logic sweep_clr, sweep_inc, done_d, err_d;

  assign sweep_nxt = sweep_q + SW_W'(1);

  // Next-state and datapath control; abort beats hold, hold freezes everything.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    en        = 1'b0;
    dir       = MODE_UP;
    sweep_clr = 1'b0;
    sweep_inc = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if ((bus.lo >= bus.hi) || (bus.n_sweeps == '0)) begin
            err_d = 1'b1;
          end else begin
            load      = 1'b1;
            sweep_clr = 1'b1;
            state_d   = ST_UP;
          end
        end
      end
      ST_UP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!bus.hold) begin
          en = 1'b1;
          if (count_w == hi_q) begin
            dir     = MODE_DOWN;
            state_d = ST_DOWN;
          end
        end
      end
      ST_DOWN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!bus.hold) begin
          if (count_w != lo_q) begin
            en  = 1'b1;
            dir = MODE_DOWN;
          end else begin
            sweep_inc = 1'b1;
            if (sweep_nxt == n_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              en      = 1'b1;
              dir     = MODE_UP;
              state_d = ST_UP;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      if (load) begin
        lo_q <= bus.lo;
        hi_q <= bus.hi;
        n_q  <= bus.n_sweeps;
      end
      if (sweep_clr) begin
        sweep_q <= '0;
      end else if (sweep_inc) begin
        sweep_q <= sweep_nxt;
      end
    end
  end

  updown_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (bus.lo),
    .en       (en),
    .mode     (dir),
    .count    (count_w)
  );

  assign bus.count = count_w;
  assign bus.mode  = (state_q == ST_UP) ? MODE_UP : MODE_DOWN;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl against a triangle-sequence model.
module tb_updown_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] last_count = 8'd0;

  logic [7:0] exp_cnt[$];
  logic       exp_mode[$];

  updown_sweep_if #(.WIDTH(8), .SW_W(4)) bus ();

  updown_sweep_ctrl #(.WIDTH(8), .SW_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected visible count/mode per busy cycle: lo, then per sweep lo+1..hi (up), hi-1..lo (down).
  task automatic build_seq(input logic [7:0] l, input logic [7:0] h, input logic [3:0] n);
    exp_cnt.delete();
    exp_mode.delete();
    exp_cnt.push_back(l);
    exp_mode.push_back(1'b1);
    for (int s = 0; s < int'(n); s++) begin
      for (int v = int'(l) + 1; v <= int'(h); v++) begin
        exp_cnt.push_back(8'(v));
        exp_mode.push_back(1'b1);
      end
      for (int v = int'(h) - 1; v >= int'(l); v--) begin
        exp_cnt.push_back(8'(v));
        exp_mode.push_back(1'b0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.lo = 8'd0; bus.hi = 8'd0; bus.n_sweeps = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.count, bus.busy, bus.done, bus.err, bus.mode} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: count=%0d busy=%b done=%b err=%b mode=%b, want 0 0 0 0 0",
               bus.count, bus.busy, bus.done, bus.err, bus.mode);
    end
    last_count = 8'd0;
  endtask

  // Full sweep run; hold for hold_len cycles at index hold_at, optional random hold/noise inputs.
  task automatic run_sweep(input string nm, input logic [7:0] l, input logic [7:0] h,
                           input logic [3:0] n, input int hold_at, input int hold_len,
                           input bit rnd);
    int idx, cyc, holds, hcnt, len, want_cyc;
    bit hh;
    build_seq(l, h, n);
    len = exp_cnt.size();
    want_cyc = 2 * (int'(h) - int'(l)) * int'(n) + 2;
    bus.lo = l; bus.hi = h; bus.n_sweeps = n; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    idx = 0; cyc = 1; holds = 0; hcnt = 0;
    while (idx < len && cyc < 2000) begin
      vectors++;
      if ({bus.count, bus.busy, bus.mode, bus.done, bus.err} !==
          {exp_cnt[idx], 1'b1, exp_mode[idx], 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL %s cyc%0d: count=%0d busy=%b mode=%b done=%b err=%b, want count=%0d busy=1 mode=%b done=0 err=0",
                 nm, cyc, bus.count, bus.busy, bus.mode, bus.done, bus.err, exp_cnt[idx], exp_mode[idx]);
      end
      hh = 1'b0;
      if (idx == hold_at && hcnt < hold_len) begin hh = 1'b1; hcnt++; end
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) hh = 1'b1;
        bus.start    = 1'($urandom_range(0, 1));
        bus.lo       = 8'($urandom);
        bus.hi       = 8'($urandom);
        bus.n_sweeps = 4'($urandom);
      end
      bus.hold = hh;
      tick();
      if (hh) holds++; else idx++;
      cyc++;
    end
    bus.start = 1'b0; bus.hold = 1'b0;
    vectors++;
    if (idx != len) begin
      miscompares++;
      $display("FAIL %s timeout: reached index %0d, want %0d", nm, idx, len);
    end
    vectors++;
    if ({bus.count, bus.busy, bus.done, bus.err} !== {l, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL %s end: count=%0d busy=%b done=%b err=%b, want count=%0d busy=0 done=1 err=0",
               nm, bus.count, bus.busy, bus.done, bus.err, l);
    end
    vectors++;
    if (cyc != want_cyc + holds) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d, want %0d", nm, cyc, want_cyc + holds);
    end
    tick();
    vectors++;
    if ({bus.count, bus.busy, bus.done} !== {l, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s after: count=%0d busy=%b done=%b, want count=%0d busy=0 done=0",
               nm, bus.count, bus.busy, bus.done, l);
    end
    last_count = l;
  endtask

  task automatic test_reject(input string nm, input logic [7:0] l, input logic [7:0] h,
                             input logic [3:0] n);
    bus.lo = l; bus.hi = h; bus.n_sweeps = n; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if ({bus.err, bus.busy, bus.done, bus.count} !== {1'b1, 1'b0, 1'b0, last_count}) begin
      miscompares++;
      $display("FAIL %s: err=%b busy=%b done=%b count=%0d, want err=1 busy=0 done=0 count=%0d",
               nm, bus.err, bus.busy, bus.done, bus.count, last_count);
    end
    tick();
    vectors++;
    if ({bus.err, bus.busy, bus.count} !== {1'b0, 1'b0, last_count}) begin
      miscompares++;
      $display("FAIL %s next: err=%b busy=%b count=%0d, want 0 0 %0d",
               nm, bus.err, bus.busy, bus.count, last_count);
    end
  endtask

  // Sweep 2..5, abort when count=4 on the way down (index 4 of the sequence).
  task automatic test_abort(input string nm, input bit with_hold);
    bus.lo = 8'd2; bus.hi = 8'd5; bus.n_sweeps = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if ({bus.count, bus.mode, bus.busy} !== {8'd4, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s pre: count=%0d mode=%b busy=%b, want 4 0 1", nm, bus.count, bus.mode, bus.busy);
    end
    bus.abort = 1'b1; bus.hold = with_hold;
    tick();
    bus.abort = 1'b0; bus.hold = 1'b0;
    vectors++;
    if ({bus.count, bus.busy, bus.done, bus.err} !== {8'd4, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: count=%0d busy=%b done=%b err=%b, want 4 0 0 0",
               nm, bus.count, bus.busy, bus.done, bus.err);
    end
    tick();
    vectors++;
    if ({bus.count, bus.busy, bus.done, bus.err} !== {8'd4, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s next: count=%0d busy=%b done=%b err=%b, want 4 0 0 0",
               nm, bus.count, bus.busy, bus.done, bus.err);
    end
    last_count = 8'd4;
  endtask

  task automatic test_reset_mid();
    bus.lo = 8'd2; bus.hi = 8'd5; bus.n_sweeps = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.count, bus.busy, bus.done, bus.err} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: count=%0d busy=%b done=%b err=%b, want 0 0 0 0",
               bus.count, bus.busy, bus.done, bus.err);
    end
    last_count = 8'd0;
  endtask

  task automatic test_random();
    logic [7:0] l, h;
    logic [3:0] n;
    for (int i = 0; i < 8; i++) begin
      l = 8'($urandom_range(0, 200));
      h = l + 8'($urandom_range(1, 9));
      n = 4'($urandom_range(1, 4));
      run_sweep("random", l, h, n, -1, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    run_sweep("basic", 8'd2, 8'd5, 4'd1, -1, 0, 1'b0);
    run_sweep("multi", 8'd0, 8'd3, 4'd3, -1, 0, 1'b0);
    run_sweep("hold", 8'd2, 8'd5, 4'd1, 2, 3, 1'b0);
    test_reject("reject_eq", 8'd7, 8'd7, 4'd1);
    test_reject("reject_inv", 8'd9, 8'd4, 4'd2);
    test_reject("reject_n0", 8'd1, 8'd6, 4'd0);
    test_abort("abort", 1'b0);
    test_reject("reject_after_abort", 8'd3, 8'd3, 4'd1);
    run_sweep("restart", 8'd1, 8'd4, 4'd2, -1, 0, 1'b0);
    test_abort("abort_hold", 1'b1);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
